core_lid_resp: RTL and testbench

Data-side memory responder for the Selen core: the slave end of the load/store handshake whose `ack` and read data the write-back stage consumes. It accepts one request at a time from the memory stage and performs the byte, halfword or word access on a local synchronous RAM after a configurable number of wait states. It returns a one-cycle ack together with lane-aligned read data, so the write-back sign/zero-extension logic only ever looks at bits [7:0] or [15:0].

---
 rtl/core_lid_resp.sv | 181 ++++++++++++++++++
 tb/tb_core_lid_resp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/core_lid_resp.sv
// Data-side memory responder: byte/half/word access to a local RAM with WAIT_CYCLES wait states and a one-cycle ack.
// Latency: ack lands WAIT_CYCLES edges after the accepting edge (immediately for error requests).
// Backpressure: busy while a transaction is in flight; requests are only sampled in IDLE. Option: CORE_LID_ERR_EN.
module core_lid_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lid_req_in,
    input  logic        lid_we_in,
    input  logic [1:0]  lid_size_in,
    input  logic [31:0] lid_addr_in,
    input  logic [31:0] lid_wdata_in,
    output logic        lid_ack_out,
    output logic [31:0] lid_rdata_out,
    output logic        lid_busy_out,
    output logic        lid_err_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        q_we;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] rdata_q;
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // The RAM access happens on the edge that enters RESP; from IDLE that is
    // the live request, from WAIT the latched copy.
    logic              a_we;
    logic [1:0]        a_size;
    logic [31:0]       a_addr, a_wdata;
    logic              a_err;
    logic              enter_resp;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       cur_word, rd_val, wr_word;
    logic [3:0]        be;

    always_comb begin
        a_we    = q_we;
        a_size  = q_size;
        a_addr  = q_addr;
        a_wdata = q_wdata;
        if (state == S_IDLE) begin
            a_we    = lid_we_in;
            a_size  = lid_size_in;
            a_addr  = lid_addr_in;
            a_wdata = lid_wdata_in;
        end
    end

`ifdef CORE_LID_ERR_EN
    always_comb begin
        a_err = 1'b0;
        case (a_size)
            2'b01:   a_err = a_addr[0];
            2'b10:   a_err = (a_addr[1:0] != 2'b00);
            2'b11:   a_err = 1'b1;
            default: a_err = 1'b0;
        endcase
        if (a_addr[31:ADDR_W+2] != '0)
            a_err = 1'b1;
    end
`else
    assign a_err = 1'b0;
    logic unused_addr_hi;
    assign unused_addr_hi = ^a_addr[31:ADDR_W+2];
`endif

    assign w_idx    = a_addr[ADDR_W+1:2];
    assign cur_word = mem[w_idx];

    // Lane steering: reads are right-aligned, writes replicate the datum and
    // rely on the byte enables to pick the lane.
    always_comb begin
        rd_val  = cur_word;
        wr_word = a_wdata;
        be      = 4'b1111;
        case (a_size)
            2'b00: begin
                rd_val  = {24'b0, cur_word[{a_addr[1:0], 3'b000} +: 8]};
                wr_word = {4{a_wdata[7:0]}};
                be      = 4'b0001 << a_addr[1:0];
            end
            2'b01: begin
                rd_val  = {16'b0, cur_word[{a_addr[1], 4'b0000} +: 16]};
                wr_word = {2{a_wdata[15:0]}};
                be      = a_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                rd_val  = cur_word;
                wr_word = a_wdata;
                be      = 4'b1111;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (lid_req_in)
                        state_nxt = (a_err || (WAIT_CYCLES == 0)) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd1)
                        state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        lid_ack_out  = 1'b0;
        lid_busy_out = 1'b0;
        if (state == S_RESP)
            lid_ack_out = 1'b1;
        if (state != S_IDLE)
            lid_busy_out = 1'b1;
    end

    assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            if (state == S_IDLE && lid_req_in)
                cnt <= 4'(WAIT_CYCLES);
            else if (state == S_WAIT)
                cnt <= cnt - 4'd1;
            if (enter_resp)
                rdata_q <= (a_we || a_err) ? 32'd0 : rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && lid_req_in) begin
            q_we    <= lid_we_in;
            q_size  <= lid_size_in;
            q_addr  <= lid_addr_in;
            q_wdata <= lid_wdata_in;
        end
    end

    // RAM has no reset; a store completing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && a_we && !a_err && !rst) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[w_idx][8*i +: 8] <= wr_word[8*i +: 8];
        end
    end

`ifdef CORE_LID_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (enter_resp)
            err_q <= a_err;
    end
    assign lid_err_out = lid_ack_out & err_q;
`else
    assign lid_err_out = 1'b0;
`endif

    assign lid_rdata_out = rdata_q;

endmodule

// File: tb/tb_core_lid_resp.sv
// Randomized + directed bench for core_lid_resp against a byte-addressed memory model.
module tb_core_lid_resp;

    localparam int ADDR_W = 10;
    localparam int W      = 1;
    localparam int BYTES  = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack, busy, err;
    logic [31:0] rdata;

    logic        b_req = 1'b0;
    logic        b_ack, b_busy, b_err;
    logic [31:0] b_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mm [int unsigned];

    always #5 clk = ~clk;

    core_lid_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .lid_req_in(req), .lid_we_in(we), .lid_size_in(size),
        .lid_addr_in(addr), .lid_wdata_in(wdata), .lid_ack_out(ack),
        .lid_rdata_out(rdata), .lid_busy_out(busy), .lid_err_out(err)
    );

    core_lid_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .lid_req_in(b_req), .lid_we_in(1'b1), .lid_size_in(2'b10),
        .lid_addr_in(32'h50), .lid_wdata_in(32'hCAFE0001), .lid_ack_out(b_ack),
        .lid_rdata_out(b_rdata), .lid_busy_out(b_busy), .lid_err_out(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory seen as a flat little-endian byte array.
    task automatic model(input logic mwe, input logic [1:0] msz, input logic [31:0] maddr,
                         input logic [31:0] mwd, output logic [31:0] exp_rd, output logic exp_err);
        int unsigned n, base;
        n = (msz == 2'b00) ? 1 : (msz == 2'b01) ? 2 : 4;
        exp_rd  = 32'd0;
        exp_err = 1'b0;
`ifdef CORE_LID_ERR_EN
        exp_err = (msz == 2'b11) || (maddr % n != 0) || (maddr >= BYTES);
`endif
        base = (maddr - (maddr % n)) % BYTES;
        if (exp_err)
            return;
        for (int unsigned k = 0; k < n; k++) begin
            if (mwe)
                mm[base + k] = mwd[8*k +: 8];
            else
                exp_rd[8*k +: 8] = mm[base + k];
        end
    endtask

    task automatic txn(input logic twe, input logic [1:0] tsz, input logic [31:0] taddr,
                       input logic [31:0] twd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model(twe, tsz, taddr, twd, exp_rd, exp_err);
        @(posedge clk); #1;
        req = 1'b1; we = twe; size = tsz; addr = taddr; wdata = twd;
        @(posedge clk); #1;
        req = 1'b0;
        chk("busy_after_req", 32'(busy), 32'd1);
        lat = 0;
        while (!ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ack_latency", 32'(lat), exp_err ? 32'd0 : 32'(W));
        chk($sformatf("rdata@%h sz%0d we%0d", taddr, tsz, twe), rdata, exp_rd);
        chk("err", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("idle_after_ack", 32'(busy), 32'd0);
        chk("rdata_hold", rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] a, hi;
        int          ack_at [$];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);

        txn(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++)
            txn(1'b0, 2'b00, 32'h10 + 32'(i), 32'd0);

        txn(1'b1, 2'b10, 32'h20, 32'h11223344);
        txn(1'b1, 2'b01, 32'h22, 32'h0000AAAA);
        txn(1'b0, 2'b10, 32'h20, 32'd0);
        txn(1'b0, 2'b01, 32'h20, 32'd0);

        // Store dropped by a reset that lands while it is waiting.
        txn(1'b1, 2'b10, 32'h30, 32'h0);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0;
        txn(1'b0, 2'b10, 32'h30, 32'd0);

        txn(1'b1, 2'b10, 32'h40, 32'h87654321);
        txn(1'b0, 2'b01, 32'h41, 32'd0);
        txn(1'b0, 2'b10, 32'h40, 32'd0);

        for (int i = 0; i < 16; i++)
            txn(1'b1, 2'b10, 32'h100 + 32'(4*i), $urandom);
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                hi = $urandom;
                a  = a | (hi << 12);
            end
            txn(1'($urandom), 2'($urandom), a, $urandom);
        end

        // WAIT_CYCLES=0 instance with req held high through the acks.
        @(posedge clk); #1;
        b_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (b_ack)
                ack_at.push_back(i);
        end
        b_req = 1'b0;
        chk("b2b_ack_count", 32'(ack_at.size()), 32'd3);
        if (ack_at.size() >= 2) begin
            chk("b2b_first_ack", 32'(ack_at[0]), 32'd0);
            chk("b2b_ack_gap", 32'(ack_at[1] - ack_at[0]), 32'd2);
        end else begin
            chk("b2b_acks_seen", 32'(ack_at.size()), 32'd2);
        end
        chk("b2b_err", 32'(b_err), 32'd0);
        chk("b2b_rdata_store", b_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
